// File: rtl/accel_tilt_processor.sv
// accel_tilt_processor: accelerometer front-end between the ADXL362 SPI
// controller and game logic. Stretches reset into a sensor hold reset,
// box-averages 2**AVG_LOG2 samples per channel and flags tilt per channel.
// Optional feature macro: HYSTERESIS_EN (tilt flags with a release band).
module accel_tilt_processor #(
  parameter int unsigned NUM_CH            = 2,
  parameter int unsigned RAW_W             = 12,
  parameter int unsigned AVG_LOG2          = 4,
  parameter int unsigned DEADZONE          = 100,
  parameter int unsigned HYST              = 20,
  parameter int unsigned RESET_HOLD_CYCLES = 1080
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      raw_valid,
  input  logic [NUM_CH*RAW_W-1:0]   raw_data,
  output logic                      hold_reset,
  output logic [NUM_CH*RAW_W-1:0]   avg_data,
  output logic [NUM_CH-1:0]         tilt_pos,
  output logic [NUM_CH-1:0]         tilt_neg,
  output logic                      out_valid,
  output logic                      overrun
);

  localparam int unsigned ACC_W  = RAW_W + AVG_LOG2;
  localparam int unsigned CNT_W  = AVG_LOG2 + 1;
  localparam int unsigned HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  LAST_SAMPLE = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(RESET_HOLD_CYCLES - 1);

  localparam logic signed [RAW_W-1:0] DZ_POS = RAW_W'(DEADZONE);
  localparam logic signed [RAW_W-1:0] DZ_NEG = -DZ_POS;
`ifdef HYSTERESIS_EN
  localparam logic signed [RAW_W-1:0] REL_POS = RAW_W'(DEADZONE - HYST);
  localparam logic signed [RAW_W-1:0] REL_NEG = -REL_POS;
`endif

  // Reject parameter sets where the thresholds cannot be represented.
  if (HYST > DEADZONE || DEADZONE >= (1 << (RAW_W - 1))) begin : g_bad_params
    $error("accel_tilt_processor: need HYST <= DEADZONE < 2**(RAW_W-1)");
  end

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DIVIDE = 2'd2
  } state_e;

  state_e                    state_q;
  logic [HOLD_W-1:0]         hold_cnt_q;
  logic                      hold_reset_q;
  logic [CNT_W-1:0]          smp_cnt_q;
  logic signed [ACC_W-1:0]   acc_q [NUM_CH];
  logic signed [ACC_W-1:0]   acc_d [NUM_CH];
  logic [NUM_CH*RAW_W-1:0]   avg_data_q;
  logic [NUM_CH*RAW_W-1:0]   avg_data_d;
  logic [NUM_CH-1:0]         tilt_pos_q;
  logic [NUM_CH-1:0]         tilt_pos_d;
  logic [NUM_CH-1:0]         tilt_neg_q;
  logic [NUM_CH-1:0]         tilt_neg_d;
  logic                      out_valid_q;
  logic                      overrun_q;

  logic signed [RAW_W-1:0]   smp    [NUM_CH];
  logic signed [RAW_W-1:0]   avg_ch [NUM_CH];

  // Per-channel accumulate, floor-divide by bit selection, and tilt decision.
  always_comb begin
    avg_data_d = '0;
    tilt_pos_d = tilt_pos_q;
    tilt_neg_d = tilt_neg_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      smp[i]    = raw_data[i*RAW_W +: RAW_W];
      acc_d[i]  = acc_q[i] + ACC_W'(smp[i]);
      // Dropping the low AVG_LOG2 bits of a two's complement sum floors toward -inf.
      avg_ch[i] = acc_q[i][AVG_LOG2 +: RAW_W];
      avg_data_d[i*RAW_W +: RAW_W] = avg_ch[i];
`ifdef HYSTERESIS_EN
      if (avg_ch[i] > DZ_POS) begin
        tilt_pos_d[i] = 1'b1;
      end else if (avg_ch[i] < REL_POS) begin
        tilt_pos_d[i] = 1'b0;
      end
      if (avg_ch[i] < DZ_NEG) begin
        tilt_neg_d[i] = 1'b1;
      end else if (avg_ch[i] > REL_NEG) begin
        tilt_neg_d[i] = 1'b0;
      end
`else
      tilt_pos_d[i] = (avg_ch[i] > DZ_POS);
      tilt_neg_d[i] = (avg_ch[i] < DZ_NEG);
`endif
    end
  end

  // Control FSM with hold counter, sample counter, accumulators and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_HOLD;
      hold_cnt_q   <= '0;
      hold_reset_q <= 1'b1;
      smp_cnt_q    <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
      end
      avg_data_q   <= '0;
      tilt_pos_q   <= '0;
      tilt_neg_q   <= '0;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        ST_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_q      <= ST_ACCUM;
            hold_reset_q <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end
        ST_ACCUM: begin
          if (raw_valid) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
              acc_q[i] <= acc_d[i];
            end
            smp_cnt_q <= smp_cnt_q + CNT_W'(1);
            if (smp_cnt_q == LAST_SAMPLE) begin
              state_q <= ST_DIVIDE;
            end
          end
        end
        ST_DIVIDE: begin
          avg_data_q  <= avg_data_d;
          tilt_pos_q  <= tilt_pos_d;
          tilt_neg_q  <= tilt_neg_d;
          out_valid_q <= 1'b1;
          smp_cnt_q   <= '0;
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            acc_q[i] <= '0;
          end
          // A strobe here cannot be accumulated; record the loss.
          if (raw_valid) begin
            overrun_q <= 1'b1;
          end
          state_q <= ST_ACCUM;
        end
        default: begin
          state_q <= ST_HOLD;
        end
      endcase
    end
  end

  assign hold_reset = hold_reset_q;
  assign avg_data   = avg_data_q;
  assign tilt_pos   = tilt_pos_q;
  assign tilt_neg   = tilt_neg_q;
  assign out_valid  = out_valid_q;
  assign overrun    = overrun_q;

endmodule
